// File: rtl/commit_trace_buffer.sv
// Commit-trace capture at the writeback stage: classify, filter, arm/trigger, show-ahead FIFO.
// Define COMMIT_TRACE_TS_EN to stamp each record with a free-running cycle counter on o_trace_ts.
module commit_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int TS_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_commit_valid,
    input  logic [XLEN-1:0]            i_commit_pc,
    input  logic [31:0]                i_commit_instr,
    input  logic [4:0]                 i_commit_rd,
    input  logic                       i_commit_reg_wr,
    input  logic                       i_commit_is_load,
    input  logic                       i_commit_is_store,
    input  logic [XLEN-1:0]            i_commit_wdata,
    input  logic [XLEN-1:0]            i_commit_mem_addr,
    input  logic [1:0]                 i_mode,
    input  logic                       i_arm,
    input  logic                       i_disarm,
    input  logic                       i_trig_en,
    input  logic [XLEN-1:0]            i_trig_pc,
    output logic                       o_trace_valid,
    input  logic                       i_trace_ready,
    output logic [1:0]                 o_trace_kind,
    output logic [XLEN-1:0]            o_trace_pc,
    output logic [31:0]                o_trace_instr,
    output logic [4:0]                 o_trace_rd,
    output logic [XLEN-1:0]            o_trace_data,
    output logic [XLEN-1:0]            o_trace_addr,
    output logic [TS_W-1:0]            o_trace_ts,
    output logic [$clog2(DEPTH):0]     o_fill_count,
    output logic [15:0]                o_overflow_cnt,
    output logic                       o_capturing
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic [15:0]       r_ovfCnt;

    logic [1:0]        r_memKind  [DEPTH];
    logic [XLEN-1:0]   r_memPc    [DEPTH];
    logic [31:0]       r_memInstr [DEPTH];
    logic [4:0]        r_memRd    [DEPTH];
    logic [XLEN-1:0]   r_memData  [DEPTH];
    logic [XLEN-1:0]   r_memAddr  [DEPTH];

    logic              w_qualify;
    logic [1:0]        w_kind;
    logic              w_pass;
    logic              w_trigHit;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_accept;
    logic              w_drop;
    logic [4:0]        w_recRd;
    logic [XLEN-1:0]   w_recAddr;

    assign w_qualify = i_commit_valid && (i_commit_instr != 32'h0);

    always_comb begin
        w_kind = 2'd0;
        if (i_commit_is_store)
            w_kind = 2'd3;
        else if (i_commit_is_load)
            w_kind = 2'd2;
        else if (i_commit_reg_wr && (i_commit_rd != 5'd0))
            w_kind = 2'd1;
    end

    always_comb begin
        w_pass = 1'b0;
        case (i_mode)
            2'b00:   w_pass = 1'b1;
            2'b01:   w_pass = w_kind[1];
            2'b10:   w_pass = (w_kind == 2'd1);
            default: w_pass = 1'b0;
        endcase
    end

    // Only loads/stores carry an address; only loads/reg-writes carry a destination.
    assign w_recRd   = (w_kind == 2'd1 || w_kind == 2'd2) ? i_commit_rd : 5'd0;
    assign w_recAddr = w_kind[1] ? i_commit_mem_addr : '0;

    assign w_trigHit = (r_state == WAIT_TRIG) && w_qualify && (i_commit_pc == i_trig_pc);
    assign w_push    = w_qualify && w_pass && ((r_state == CAPTURE) || w_trigHit);
    assign w_pop     = o_trace_valid && i_trace_ready;
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_accept  = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (i_disarm) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:      if (i_arm) r_state <= i_trig_en ? WAIT_TRIG : CAPTURE;
                WAIT_TRIG: if (w_trigHit) r_state <= CAPTURE;
                CAPTURE:   r_state <= CAPTURE;
                default:   r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_count  <= '0;
            r_ovfCnt <= 16'd0;
        end else begin
            if (w_accept)
                r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)
                r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_ovfCnt != 16'hFFFF))
                r_ovfCnt <= r_ovfCnt + 16'd1;
        end
    end

    // When full with a same-cycle pop, r_wrPtr equals r_rdPtr and overwrites the departing head.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_memKind[r_wrPtr]  <= w_kind;
            r_memPc[r_wrPtr]    <= i_commit_pc;
            r_memInstr[r_wrPtr] <= i_commit_instr;
            r_memRd[r_wrPtr]    <= w_recRd;
            r_memData[r_wrPtr]  <= i_commit_wdata;
            r_memAddr[r_wrPtr]  <= w_recAddr;
        end
    end

`ifdef COMMIT_TRACE_TS_EN
    logic [TS_W-1:0] r_tsCnt;
    logic [TS_W-1:0] r_memTs [DEPTH];

    always_ff @(posedge clk) begin
        if (rst)
            r_tsCnt <= '0;
        else
            r_tsCnt <= r_tsCnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_accept)
            r_memTs[r_wrPtr] <= r_tsCnt;
    end

    assign o_trace_ts = r_memTs[r_rdPtr];
`else
    assign o_trace_ts = '0;
`endif

    assign o_trace_valid  = (r_count != '0);
    assign o_trace_kind   = r_memKind[r_rdPtr];
    assign o_trace_pc     = r_memPc[r_rdPtr];
    assign o_trace_instr  = r_memInstr[r_rdPtr];
    assign o_trace_rd     = r_memRd[r_rdPtr];
    assign o_trace_data   = r_memData[r_rdPtr];
    assign o_trace_addr   = r_memAddr[r_rdPtr];
    assign o_fill_count   = r_count;
    assign o_overflow_cnt = r_ovfCnt;
    assign o_capturing    = (r_state == CAPTURE);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: queue-based reference model plus directed literal checks.
module tb_commit_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int TS_W  = 32;

    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] NOP0 = 32'h00000013;
    localparam logic [31:0] LW   = 32'h00002103;
    localparam logic [31:0] SW   = 32'h00202023;
    localparam logic [31:0] BEQ  = 32'h00000463;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cValid = 1'b0;
    logic [31:0]     cPc = '0;
    logic [31:0]     cInstr = '0;
    logic [4:0]      cRd = '0;
    logic            cRegWr = 1'b0;
    logic            cLd = 1'b0;
    logic            cSt = 1'b0;
    logic [31:0]     cData = '0;
    logic [31:0]     cAddr = '0;
    logic [1:0]      mode = 2'b00;
    logic            arm = 1'b0;
    logic            disarm = 1'b0;
    logic            trigEn = 1'b0;
    logic [31:0]     trigPc = '0;
    logic            ready = 1'b0;

    logic            oValid;
    logic [1:0]      oKind;
    logic [31:0]     oPc;
    logic [31:0]     oInstr;
    logic [4:0]      oRd;
    logic [31:0]     oData;
    logic [31:0]     oAddr;
    logic [TS_W-1:0] oTs;
    logic [4:0]      oFill;
    logic [15:0]     oOvf;
    logic            oCapturing;

    commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .rst(rst),
        .i_commit_valid(cValid), .i_commit_pc(cPc), .i_commit_instr(cInstr),
        .i_commit_rd(cRd), .i_commit_reg_wr(cRegWr), .i_commit_is_load(cLd),
        .i_commit_is_store(cSt), .i_commit_wdata(cData), .i_commit_mem_addr(cAddr),
        .i_mode(mode), .i_arm(arm), .i_disarm(disarm), .i_trig_en(trigEn), .i_trig_pc(trigPc),
        .o_trace_valid(oValid), .i_trace_ready(ready), .o_trace_kind(oKind),
        .o_trace_pc(oPc), .o_trace_instr(oInstr), .o_trace_rd(oRd), .o_trace_data(oData),
        .o_trace_addr(oAddr), .o_trace_ts(oTs), .o_fill_count(oFill),
        .o_overflow_cnt(oOvf), .o_capturing(oCapturing)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nFailed   = 0;
    bit checkEn   = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: a record queue and a three-valued session state.
    typedef struct {
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] addr;
    } rec_t;

    rec_t mq[$];
    int   mOvf = 0;
    int   mState = 0;
    rec_t mRec;
    bit   mQual, mPass, mHit, mPush, mPop;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mOvf   = 0;
            mState = 0;
        end else begin
            mQual = cValid && (cInstr != 0);
            if (cSt)                        mRec.kind = 2'd3;
            else if (cLd)                   mRec.kind = 2'd2;
            else if (cRegWr && cRd != 0)    mRec.kind = 2'd1;
            else                            mRec.kind = 2'd0;
            mRec.pc    = cPc;
            mRec.instr = cInstr;
            mRec.rd    = (mRec.kind == 1 || mRec.kind == 2) ? cRd : 5'd0;
            mRec.data  = cData;
            mRec.addr  = (mRec.kind >= 2) ? cAddr : 32'd0;
            mPass = (mode == 0) || (mode == 1 && mRec.kind >= 2) || (mode == 2 && mRec.kind == 1);
            mHit  = (mState == 1) && mQual && (cPc == trigPc);
            mPush = mQual && mPass && (mState == 2 || mHit);
            mPop  = (mq.size() > 0) && ready;
            if (mPop) void'(mq.pop_front());
            if (mPush) begin
                if (mq.size() < DEPTH) mq.push_back(mRec);
                else if (mOvf < 16'hFFFF) mOvf++;
            end
            if (disarm)                     mState = 0;
            else if (mState == 0 && arm)    mState = trigEn ? 1 : 2;
            else if (mHit)                  mState = 2;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("valid", oValid, mq.size() > 0);
            checkOutput("fill_count", oFill, mq.size());
            checkOutput("overflow_cnt", oOvf, mOvf);
            checkOutput("capturing", oCapturing, mState == 2);
`ifndef COMMIT_TRACE_TS_EN
            checkOutput("trace_ts", oTs, 0);
`endif
            if (mq.size() > 0) begin
                checkOutput("head_kind", oKind, mq[0].kind);
                checkOutput("head_pc", oPc, mq[0].pc);
                checkOutput("head_instr", oInstr, mq[0].instr);
                checkOutput("head_rd", oRd, mq[0].rd);
                checkOutput("head_data", oData, mq[0].data);
                checkOutput("head_addr", oAddr, mq[0].addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                                 input logic rw, input logic ld, input logic st,
                                 input logic [31:0] data, input logic [31:0] addr);
        cValid = 1'b1; cPc = pc; cInstr = instr; cRd = rd;
        cRegWr = rw; cLd = ld; cSt = st; cData = data; cAddr = addr;
        tick();
        cValid = 1'b0; cInstr = '0; cRegWr = 1'b0; cLd = 1'b0; cSt = 1'b0;
    endtask

    task automatic pulseArm(input logic te, input logic [1:0] md);
        mode = md; trigEn = te; arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulseDisarm();
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
    endtask

    task automatic drain();
        ready = 1'b1;
        repeat (DEPTH + 1) tick();
        ready = 1'b0;
    endtask

    initial begin
        logic [31:0] expPc;

        repeat (5) tick();
        rst = 1'b0;
        checkEn = 1'b1;
        checkOutput("rst_valid", oValid, 0);
        checkOutput("rst_fill", oFill, 0);
        checkOutput("rst_ovf", oOvf, 0);
        checkOutput("rst_capturing", oCapturing, 0);
        applyStimulus(32'h8, SW, 5'd0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h4);
        checkOutput("idle_ignore_fill", oFill, 0);

        pulseArm(1'b0, 2'b00);
        checkOutput("arm_capturing", oCapturing, 1);
        applyStimulus(32'h10, SW, 5'd5, 1'b0, 1'b0, 1'b1, 32'hAB, 32'h100);
        checkOutput("sw_valid", oValid, 1);
        checkOutput("sw_kind", oKind, 3);
        checkOutput("sw_addr", oAddr, 32'h100);
        checkOutput("sw_data", oData, 32'hAB);
        checkOutput("sw_rd", oRd, 0);
        drain();
        pulseDisarm();
        checkOutput("disarm_capturing", oCapturing, 0);

        trigPc = 32'h40;
        pulseArm(1'b1, 2'b00);
        checkOutput("wait_capturing", oCapturing, 0);
        for (int i = 0; i < 4; i++) begin
            expPc = 32'h38 + 32'(4 * i);
            applyStimulus(expPc, ADDI, 5'd1, 1'b1, 1'b0, 1'b0, expPc, expPc);
        end
        checkOutput("trig_fill", oFill, 2);
        checkOutput("trig_head_pc", oPc, 32'h40);
        checkOutput("trig_head_addr", oAddr, 0);
        ready = 1'b1;
        tick();
        checkOutput("trig_second_pc", oPc, 32'h44);
        tick();
        ready = 1'b0;
        checkOutput("trig_drained", oFill, 0);
        pulseDisarm();

        pulseArm(1'b0, 2'b00);
        for (int i = 0; i < 20; i++)
            applyStimulus(32'h1000 + 32'(4 * i), ADDI, 5'd2, 1'b1, 1'b0, 1'b0, 32'(i), 32'h0);
        checkOutput("ovf_fill", oFill, 16);
        checkOutput("ovf_cnt", oOvf, 4);
        checkOutput("ovf_head_pc", oPc, 32'h1000);
        tick();
        checkOutput("ovf_fill_hold", oFill, 16);
        ready = 1'b1;
        applyStimulus(32'h2000, ADDI, 5'd2, 1'b1, 1'b0, 1'b0, 32'h99, 32'h0);
        checkOutput("pushpop_fill", oFill, 16);
        checkOutput("pushpop_ovf", oOvf, 4);
        checkOutput("pushpop_head_pc", oPc, 32'h1004);
        for (int i = 0; i < 16; i++) begin
            expPc = (i < 15) ? 32'h1004 + 32'(4 * i) : 32'h2000;
            checkOutput("drain_pc", oPc, expPc);
            tick();
        end
        ready = 1'b0;
        checkOutput("drain_empty", oValid, 0);
        checkOutput("drain_ovf_kept", oOvf, 4);

        pulseDisarm();
        pulseArm(1'b0, 2'b01);
        applyStimulus(32'h50, ADDI, 5'd3, 1'b1, 1'b0, 1'b0, 32'h5, 32'h0);
        applyStimulus(32'h54, LW,   5'd4, 1'b1, 1'b1, 1'b0, 32'h11, 32'h200);
        applyStimulus(32'h58, SW,   5'd9, 1'b0, 1'b0, 1'b1, 32'h22, 32'h204);
        applyStimulus(32'h5C, BEQ,  5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("mem_fill", oFill, 2);
        checkOutput("mem_lw_kind", oKind, 2);
        checkOutput("mem_lw_rd", oRd, 4);
        checkOutput("mem_lw_addr", oAddr, 32'h200);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checkOutput("mem_sw_kind", oKind, 3);
        checkOutput("mem_sw_rd", oRd, 0);
        drain();

        mode = 2'b00;
        applyStimulus(32'h60, NOP0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h5, 32'h77);
        checkOutput("rd0_kind", oKind, 0);
        checkOutput("rd0_addr", oAddr, 0);
        drain();
        mode = 2'b11;
        applyStimulus(32'h64, ADDI, 5'd1, 1'b1, 1'b0, 1'b0, 32'h1, 32'h0);
        checkOutput("mode_off_fill", oFill, 0);
        mode = 2'b10;
        applyStimulus(32'h68, SW,   5'd0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h300);
        applyStimulus(32'h6C, ADDI, 5'd7, 1'b1, 1'b0, 1'b0, 32'h3, 32'h0);
        checkOutput("mode_reg_fill", oFill, 1);
        checkOutput("mode_reg_kind", oKind, 1);
        drain();
        mode = 2'b00;
        applyStimulus(32'h70, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h1, 32'h0);
        checkOutput("bubble_fill", oFill, 0);
        disarm = 1'b1;
        applyStimulus(32'h74, ADDI, 5'd6, 1'b1, 1'b0, 1'b0, 32'h74, 32'h0);
        disarm = 1'b0;
        checkOutput("disarm_push_fill", oFill, 1);
        checkOutput("disarm_push_cap", oCapturing, 0);
        applyStimulus(32'h78, ADDI, 5'd6, 1'b1, 1'b0, 1'b0, 32'h78, 32'h0);
        checkOutput("idle_persist_fill", oFill, 1);

        pulseArm(1'b0, 2'b00);
        applyStimulus(32'h7C, ADDI, 5'd6, 1'b1, 1'b0, 1'b0, 32'h7C, 32'h0);
        checkOutput("pre_rst_fill", oFill, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_fill", oFill, 0);
        checkOutput("midrst_capturing", oCapturing, 0);
        checkOutput("midrst_ovf", oOvf, 0);
        repeat (3) tick();

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
